ucq_bcast: RTL and testbench

Parametrised unit-clause broadcast fabric connecting N BCP lanes. It accepts implied literals from each lane's UCQ_in side and arbitrates them round-robin. Each accepted literal is checked against an assignment CAM for duplicates and contradictions, then broadcast into one per-lane output FIFO feeding that lane's BCP engine. It generalises the single-lane UCQ_in/UCQ_out pairing to N lanes and adds conflict detection and flush.

---
 rtl/ucq_bcast.sv | 254 +++++++++++++++++++++++++
 tb/tb_ucq_bcast.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucq_bcast.sv
// ucq_bcast: round-robin arbitration of implied literals, assignment-CAM check, N-way broadcast.
// Latency: grant to out_valid 1 cycle; backpressure: no grant unless every FIFO has room and CAM not full.
// Build option UCQ_BCAST_DEDUP_EN: literals already in the CAM are dropped and counted in dup_cnt.

// ucq_bcast_fifo: first-word fall-through FIFO, head forced to zero while empty.
// Latency: push visible on out_dat one cycle later.
// Backpressure: push while full is ignored (caller gates on full); pop while empty is ignored.
module ucq_bcast_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign out_vld = (cnt_q != '0);
    assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
    assign do_push = push_vld && !full;
    assign do_pop  = pop && out_vld;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// ucq_bcast: N-lane unit-clause broadcast with conflict detection and flush.
// Latency: grant to out_valid 1 cycle, CAM lookup combinational on the granted literal.
// Backpressure: in_ready held low on a full FIFO, full CAM, flush, reset or after a conflict.
module ucq_bcast #(
    parameter int N_LANE    = 4,
    parameter int LIT_W     = 16,
    parameter int DEPTH     = 8,
    parameter int CAM_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_LANE-1:0]       in_valid,
    input  logic [N_LANE*LIT_W-1:0] in_lit,
    output logic [N_LANE-1:0]       in_ready,
    output logic [N_LANE-1:0]       out_valid,
    output logic [N_LANE*LIT_W-1:0] out_lit,
    input  logic [N_LANE-1:0]       out_pop,
    output logic                    conflict,
    output logic [LIT_W-1:0]        conflict_lit,
    output logic                    cam_full,
    output logic [15:0]             dup_cnt,
    output logic                    busy
);
    localparam int PW  = $clog2(N_LANE);
    localparam int CW  = $clog2(CAM_DEPTH + 1);
    localparam int CAW = $clog2(CAM_DEPTH);

    typedef enum logic {ST_RUN, ST_CONFLICT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [LIT_W-1:0] cam_q [CAM_DEPTH];
    logic [LIT_W-1:0] cam_d [CAM_DEPTH];
    logic [CW-1:0]    cam_cnt_q, cam_cnt_d;
    logic             conflict_q, conflict_d;
    logic [LIT_W-1:0] conflict_lit_q, conflict_lit_d;

    logic [N_LANE-1:0] fifo_full;
    logic              eligible, gnt_vld;
    logic [PW-1:0]     gnt_idx;
    logic [LIT_W-1:0]  gnt_lit, neg_lit;
    logic              hit_pos, hit_neg;
    logic              take_conflict, take_dup, take_new, bcast;
    int                idx;

    assign cam_full     = (cam_cnt_q == CW'(CAM_DEPTH));
    assign eligible     = !rst && !flush && (state_q == ST_RUN) && !(|fifo_full) && !cam_full;
    assign conflict     = conflict_q;
    assign conflict_lit = conflict_lit_q;
    assign busy         = |out_valid;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        in_ready = '0;
        idx      = 0;
        for (int k = 0; k < N_LANE; k++) begin
            idx = int'(p_q) + k;
            if (idx >= N_LANE) idx = idx - N_LANE;
            if (eligible && !gnt_vld && in_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (gnt_vld) in_ready[gnt_idx] = 1'b1;
    end

    assign gnt_lit = in_lit[int'(gnt_idx)*LIT_W +: LIT_W];
    assign neg_lit = ~gnt_lit + LIT_W'(1);

    // Entries at or above cam_cnt_q are stale after a flush and must not match.
    always_comb begin
        hit_pos = 1'b0;
        hit_neg = 1'b0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            if (i < int'(cam_cnt_q)) begin
                if (cam_q[i] == gnt_lit) hit_pos = 1'b1;
                if (cam_q[i] == neg_lit) hit_neg = 1'b1;
            end
        end
    end

    assign take_conflict = gnt_vld && (gnt_lit != '0) && hit_neg;
    assign take_dup      = gnt_vld && (gnt_lit != '0) && !hit_neg && hit_pos;
    assign take_new      = gnt_vld && (gnt_lit != '0) && !hit_neg && !hit_pos;

`ifdef UCQ_BCAST_DEDUP_EN
    logic [15:0] dup_cnt_q, dup_cnt_d;

    assign bcast   = take_new;
    assign dup_cnt = dup_cnt_q;

    always_comb begin
        dup_cnt_d = dup_cnt_q;
        if (take_dup && dup_cnt_q != 16'hFFFF) dup_cnt_d = dup_cnt_q + 16'd1;
    end

    // Survives flush on purpose: only rst clears the duplicate statistic.
    always_ff @(posedge clk) begin
        if (rst) dup_cnt_q <= '0;
        else     dup_cnt_q <= dup_cnt_d;
    end
`else
    assign bcast   = take_new || take_dup;
    assign dup_cnt = 16'h0000;
`endif

    always_comb begin
        state_d        = state_q;
        p_d            = p_q;
        cam_d          = cam_q;
        cam_cnt_d      = cam_cnt_q;
        conflict_d     = conflict_q;
        conflict_lit_d = conflict_lit_q;
        if (flush) begin
            state_d        = ST_RUN;
            p_d            = '0;
            cam_cnt_d      = '0;
            conflict_d     = 1'b0;
            conflict_lit_d = '0;
        end else begin
            if (gnt_vld) begin
                p_d = (gnt_idx == PW'(N_LANE - 1)) ? '0 : gnt_idx + PW'(1);
            end
            case (state_q)
                ST_RUN: begin
                    if (take_conflict) begin
                        state_d        = ST_CONFLICT;
                        conflict_d     = 1'b1;
                        conflict_lit_d = gnt_lit;
                    end
                    if (take_new) begin
                        cam_d[cam_cnt_q[CAW-1:0]] = gnt_lit;
                        cam_cnt_d                 = cam_cnt_q + CW'(1);
                    end
                end
                ST_CONFLICT: state_d = ST_CONFLICT;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            p_q            <= '0;
            cam_cnt_q      <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            cam_cnt_q      <= cam_cnt_d;
            conflict_q     <= conflict_d;
            conflict_lit_q <= conflict_lit_d;
        end
    end

    always_ff @(posedge clk) begin
        cam_q <= cam_d;
    end

    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        ucq_bcast_fifo #(
            .W     (LIT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .push_vld (bcast),
            .push_dat (gnt_lit),
            .pop      (out_pop[g]),
            .out_vld  (out_valid[g]),
            .out_dat  (out_lit[g*LIT_W +: LIT_W]),
            .full     (fifo_full[g])
        );
    end
endmodule

// File: tb/tb_ucq_bcast.sv
// Scoreboard bench for ucq_bcast: expected per-lane FIFO contents are queued on acceptance.
module tb_ucq_bcast;
    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst, flush;
    logic [N-1:0]   in_valid, in_ready, out_valid, out_pop;
    logic [N*W-1:0] in_lit, out_lit;
    logic           conflict, cam_full, busy;
    logic [W-1:0]   conflict_lit;
    logic [15:0]    dup_cnt;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] m_cam [$];
    int           m_dup = 0;
    bit           m_conf = 0;
    logic [W-1:0] m_conf_lit = '0;

    ucq_bcast #(.N_LANE(N), .LIT_W(W), .DEPTH(D), .CAM_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_lit(in_lit),
        .in_ready(in_ready), .out_valid(out_valid), .out_lit(out_lit), .out_pop(out_pop),
        .conflict(conflict), .conflict_lit(conflict_lit), .cam_full(cam_full),
        .dup_cnt(dup_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int l = 0; l < N; l++) exp_q[l].delete();
        m_cam.delete();
        m_conf     = 0;
        m_conf_lit = '0;
    endtask

    task automatic model_accept(input logic [W-1:0] lit);
        logic [W-1:0] neg;
        bit fpos, fneg;
        neg  = ~lit + 16'd1;
        fpos = 0;
        fneg = 0;
        if (lit == '0) return;
        foreach (m_cam[i]) begin
            if (m_cam[i] == lit) fpos = 1;
            if (m_cam[i] == neg) fneg = 1;
        end
        if (fneg) begin
            m_conf     = 1;
            m_conf_lit = lit;
        end else if (fpos) begin
`ifdef UCQ_BCAST_DEDUP_EN
            if (m_dup < 65535) m_dup++;
`else
            for (int l = 0; l < N; l++) exp_q[l].push_back(lit);
`endif
        end else begin
            m_cam.push_back(lit);
            for (int l = 0; l < N; l++) exp_q[l].push_back(lit);
        end
    endtask

    task automatic send(input int lane, input logic [W-1:0] lit);
        int c;
        bit got;
        c   = 0;
        got = 0;
        @(negedge clk);
        in_valid[lane]        = 1'b1;
        in_lit[lane*W +: W]   = lit;
        #1;
        while (!got && c < 40) begin
            if (in_ready[lane]) got = 1;
            else begin
                @(negedge clk); #1;
                c++;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL grant_timeout lane %0d lit %h: in_ready=0 required 1", lane, lit);
        end else begin
            @(posedge clk);
            model_accept(lit);
        end
        @(negedge clk);
        in_valid[lane] = 1'b0;
    endtask

    task automatic drain_lane(input int lane);
        logic [W-1:0] e;
        for (int c = 0; c < D + 2; c++) begin
            @(negedge clk); #1;
            if (!out_valid[lane]) break;
            tests++;
            if (exp_q[lane].size() == 0) begin
                fails++;
                $display("FAIL drain_extra lane %0d: got %h, required empty", lane, out_lit[lane*W +: W]);
            end else begin
                e = exp_q[lane].pop_front();
                if (out_lit[lane*W +: W] !== e) begin
                    fails++;
                    $display("FAIL drain_data lane %0d: got %h required %h", lane, out_lit[lane*W +: W], e);
                end
            end
            out_pop[lane] = 1'b1;
            @(posedge clk); #1;
            out_pop[lane] = 1'b0;
        end
        tests++;
        if (exp_q[lane].size() != 0) begin
            fails++;
            $display("FAIL drain_missing lane %0d: %0d entries never appeared", lane, exp_q[lane].size());
        end
    endtask

    task automatic drain_all();
        for (int l = 0; l < N; l++) drain_lane(l);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
        @(negedge clk); #1;
        tests++;
        if ({out_valid, conflict, cam_full, conflict_lit} !== '0) begin
            fails++;
            $display("FAIL flush_state: out_valid=%b conflict=%b cam_full=%b conflict_lit=%h required all 0",
                     out_valid, conflict, cam_full, conflict_lit);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        in_valid = 4'b0001;
        in_lit[0 +: W] = 16'd1;
        #1;
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_in_ready: got %b required 0000", in_ready);
        end
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({out_valid, out_lit, conflict, conflict_lit, cam_full, dup_cnt, busy, in_ready} !== '0) begin
            fails++;
            $display("FAIL reset_values: out_valid=%b out_lit=%h conflict=%b lit=%h cam_full=%b dup=%0d busy=%b",
                     out_valid, out_lit, conflict, conflict_lit, cam_full, dup_cnt, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy [5];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        in_valid = 4'b0111;
        in_lit[0*W +: W] = 16'd5;
        in_lit[1*W +: W] = 16'd7;
        in_lit[2*W +: W] = 16'd9;
        for (int s = 0; s < 5; s++) begin
            if (s == 3) begin
                in_valid = 4'b1001;
                in_lit[0*W +: W] = 16'd11;
                in_lit[3*W +: W] = 16'd13;
            end
            #1;
            tests++;
            if (in_ready !== exp_rdy[s]) begin
                fails++; $display("FAIL rr_grant step %0d: got %b required %b", s, in_ready, exp_rdy[s]);
            end
            @(posedge clk);
            model_accept(in_lit[$clog2(exp_rdy[s])*W +: W]);
            @(negedge clk);
            in_valid = in_valid & ~exp_rdy[s];
        end
        tests++;
        if (out_valid !== 4'b1111 || busy !== 1'b1) begin
            fails++; $display("FAIL rr_out_valid: got %b busy %b required 1111 1", out_valid, busy);
        end
        drain_all();
    endtask

    task automatic test_conflict();
        do_flush();
        send(1, 16'd12);
        send(3, 16'hFFF4);
        #1;
        tests++;
        if (conflict !== m_conf || conflict_lit !== m_conf_lit || !m_conf) begin
            fails++; $display("FAIL conflict_flag: got %b/%h required 1/fff4", conflict, conflict_lit);
        end
        in_valid[0] = 1'b1;
        in_lit[0 +: W] = 16'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            tests++;
            if (in_ready !== 4'b0000) begin
                fails++; $display("FAIL conflict_hold cycle %0d: in_ready got %b required 0000", c, in_ready);
            end
        end
        in_valid = '0;
        drain_all();
        do_flush();
        send(0, 16'd3);
        drain_all();
    endtask

    task automatic test_dup();
        do_flush();
        send(0, 16'd4);
        send(0, 16'd4);
        #1;
        tests++;
        if (dup_cnt !== 16'(m_dup)) begin
            fails++; $display("FAIL dup_cnt: got %0d required %0d", dup_cnt, m_dup);
        end
        drain_all();
        do_flush();
        tests++;
        if (dup_cnt !== 16'(m_dup)) begin
            fails++; $display("FAIL dup_cnt_after_flush: got %0d required %0d", dup_cnt, m_dup);
        end
    endtask

    task automatic test_fifo_full();
        logic [W-1:0] e;
        do_flush();
        for (int i = 0; i < D; i++) send(0, 16'(100 + i));
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_lit[1*W +: W] = 16'd200;
        #1;
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL full_block: in_ready got %b required 0000", in_ready);
        end
        drain_lane(0);
        drain_lane(1);
        drain_lane(3);
        @(negedge clk); #1;
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL full_lane2_block: in_ready got %b required 0000", in_ready);
        end
        e = exp_q[2].pop_front();
        tests++;
        if (out_lit[2*W +: W] !== e) begin
            fails++; $display("FAIL full_lane2_head: got %h required %h", out_lit[2*W +: W], e);
        end
        out_pop[2] = 1'b1;
        @(posedge clk); #1;
        out_pop[2] = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++; $display("FAIL full_resume: in_ready got %b required 0010", in_ready);
        end
        @(posedge clk);
        model_accept(16'd200);
        #1;
        in_valid[1] = 1'b0;
        drain_all();
    endtask

    task automatic test_cam_full();
        do_flush();
        for (int i = 0; i < 8; i++) send(2, 16'(300 + i));
        tests++;
        if (cam_full !== 1'b0) begin
            fails++; $display("FAIL cam_half: cam_full got %b required 0", cam_full);
        end
        drain_all();
        for (int i = 0; i < 8; i++) send(2, 16'(400 + i));
        drain_all();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_lit[0 +: W] = 16'd500;
        #1;
        tests++;
        if (cam_full !== 1'b1 || in_ready !== 4'b0000) begin
            fails++; $display("FAIL cam_full_block: cam_full=%b in_ready=%b required 1 0000", cam_full, in_ready);
        end
        in_valid = '0;
        do_flush();
    endtask

    task automatic test_flush_priority();
        do_flush();
        send(0, 16'd55);
        @(negedge clk);
        flush = 1'b1;
        in_valid[1] = 1'b1;
        in_lit[1*W +: W] = 16'd66;
        out_pop = '1;
        #1;
        tests++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL flush_grant: in_ready got %b required 0000", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = '0;
        out_pop = '0;
        model_clear();
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_outputs: out_valid=%b busy=%b required 0000 0", out_valid, busy);
        end
        send(0, 16'd55);
        drain_all();
    endtask

    task automatic test_reset_mid();
        do_flush();
        send(0, 16'd21);
        send(1, 16'd22);
        send(2, 16'd23);
        send(3, 16'd24);
        send(0, 16'd21);
        send(0, 16'hFFEA);
        #1;
        tests++;
        if (conflict !== 1'b1 || out_valid !== 4'b1111) begin
            fails++; $display("FAIL mid_setup: conflict=%b out_valid=%b required 1 1111", conflict, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        m_dup = 0;
        @(negedge clk); #1;
        tests++;
        if ({out_valid, out_lit, conflict, conflict_lit, cam_full, dup_cnt, busy, in_ready} !== '0) begin
            fails++;
            $display("FAIL mid_reset_values: out_valid=%b out_lit=%h conflict=%b lit=%h cam_full=%b dup=%0d busy=%b",
                     out_valid, out_lit, conflict, conflict_lit, cam_full, dup_cnt, busy);
        end
        in_valid = 4'b0011;
        in_lit[0*W +: W] = 16'd31;
        in_lit[1*W +: W] = 16'd32;
        #1;
        tests++;
        if (in_ready !== 4'b0001) begin
            fails++; $display("FAIL mid_pointer: in_ready got %b required 0001", in_ready);
        end
        @(posedge clk);
        model_accept(16'd31);
        @(negedge clk);
        in_valid = 4'b0010;
        @(posedge clk);
        model_accept(16'd32);
        @(negedge clk);
        in_valid = '0;
        drain_all();
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = '0;
        in_lit   = '0;
        out_pop  = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_round_robin();
        test_conflict();
        test_dup();
        test_fifo_full();
        test_cam_full();
        test_flush_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
